mdu_hilo_ctrl: RTL and testbench
================================

Name: mdu_hilo_ctrl

Overview:
- Sequences the MULT/MULTU/DIV/DIVU/MTHI/MTLO group in the EX stage and owns the architectural HI/LO registers.
- Latches operands, runs a multi-cycle multiply or a 32-step iterative divide, stalls the pipeline while busy, and commits results to HI/LO.
- Honours pipeline flush (exception/ERET) at any point.
- MFHI/MFLO read hi_out/lo_out directly.

Parameters:
- MUL_CYCLES, 2, number of MUL-state cycles before product commit (>=1).
- DIV_STEPS, 32, divider iteration count; fixed for 32-bit operands.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- ex_valid  in  1  valid instruction in EX.
- ex_mdu_op  in  3  decoded op: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- ex_rs  in  32  rs operand (dividend/multiplicand; MTHI/MTLO source).
- ex_rt  in  32  rt operand (divisor/multiplier).
- flush  in  1  cancel EX instruction and any in-flight operation.
- ex_stall  out  1  hold EX and earlier stages (combinational).
- busy  out  1  state != IDLE (registered).
- hi_out  out  32  architectural HI.
- lo_out  out  32  architectural LO.

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi_out=0, lo_out=0, busy=0, step counter=0, operand latches=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - ex_valid & ~flush & op in {MULT,MULTU}: latch operands and signedness; go to MUL; ex_stall=1.
  - ex_valid & ~flush & op in {DIV,DIVU}: latch |rs|, |rt| (signed) or raw (unsigned), plus sign bits; go to DIV; ex_stall=1.
  - ex_valid & ~flush & MTHI/MTLO: write hi_out/lo_out with ex_rs at the clock edge; no stall; stay IDLE.
  - Otherwise ex_stall=0.
- MUL:
  - Counter runs 0..MUL_CYCLES-1; ex_stall=1.
  - On the last cycle's edge, {HI,LO} <= 64-bit product (signed MULT, unsigned MULTU); go to DONE.
- DIV:
  - One restoring quotient bit per cycle for DIV_STEPS cycles; ex_stall=1.
  - On the last step's edge, LO <= quotient and HI <= remainder, sign-corrected; go to DONE.
  - Signed correction: quotient negated if sign(rs)^sign(rt); remainder takes the sign of rs.
  - Divisor=0: quotient=0xFFFFFFFF (before correction), remainder=dividend; no trap.
  - 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0.
- DONE:
  - Exactly one cycle; ex_stall=0 so the completed instruction leaves EX.
  - New ops are ignored; next state IDLE.
  - hi_out/lo_out already hold the new values.
- Stall totals:
  - MULT/MULTU: 1+MUL_CYCLES cycles (3 by default).
  - DIV/DIVU: 1+DIV_STEPS cycles (33).
- Flush:
  - Any state: next state IDLE.
  - ex_stall forced 0 combinationally in the same cycle.
  - HI/LO unchanged, including when flush coincides with the commit edge (flush wins).
- flush & MTHI/MTLO in IDLE: no write.
- ex_valid=0 in MUL/DIV: operation continues; the instruction is held upstream.
- Reset mid-operation: immediate IDLE; HI/LO cleared.
- Back-to-back MDU ops: the second op launches in the IDLE cycle after DONE.
- Internal widths: divider remainder register 33 bits, product 64 bits; all output arithmetic is modulo 2^32.

Decomposition:
- Add MDU op encodings (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO) and FSM state encodings to defines.h.
- Sub-module div_iter: restoring divider with start/done and 32-bit quotient/remainder, operating on unsigned magnitudes.
- Sign handling and HI/LO ownership stay in mdu_hilo_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFD, rt=5 -> ex_stall high exactly 3 cycles; in DONE, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; a following DIVU launches on the cycle after DONE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> 33 stall cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- MTHI 0x1234 then MTLO 0xABCD, no stall -> hi_out=0x1234, lo_out=0xABCD next cycle. Both repeated with flush -> no change.
- DIV started, flush at DIV step 10 -> ex_stall=0 that cycle, busy=0 next cycle, HI/LO unchanged; flush on the commit edge also leaves HI/LO unchanged.
- resetn pulsed low at DIV step 20 -> state IDLE, hi_out=lo_out=0 immediately; a new MULT 2*3 afterwards gives LO=6, HI=0.

Source files
------------

// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: decoded MDU ops,
// controller FSM states and a small conditional-negate helper.
package mdu_hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Two's-complement negate when neg is set (modulo 2^32).
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider on unsigned 32-bit magnitudes. start loads the operands;
// each cycle with step high retires one quotient bit. quotient/remainder show
// the result of the step in progress, so on the cycle where last is high the
// caller can commit them on that same edge.
module div_iter #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] q_r;
  logic [31:0] r_r;
  logic [31:0] d_r;
  logic [5:0]  cnt_r;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] q_nxt;
  logic [31:0] r_nxt;

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor in 33 bits and keep the difference when it does not borrow.
  // The partial remainder is always below the divisor, so it fits 32 bits.
  always_comb begin
    shifted = {r_r, q_r[31]};
    diff    = shifted - {1'b0, d_r};
    if (!diff[32]) begin
      r_nxt = diff[31:0];
      q_nxt = {q_r[30:0], 1'b1};
    end else begin
      r_nxt = shifted[31:0];
      q_nxt = {q_r[30:0], 1'b0};
    end
  end

  assign last      = step && (cnt_r == 6'(STEPS - 1));
  assign quotient  = q_nxt;
  assign remainder = r_nxt;

  // Operand load on start, otherwise advance one step per enabled cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      cnt_r <= '0;
    end else if (start) begin
      q_r   <= dividend;
      r_r   <= '0;
      d_r   <= divisor;
      cnt_r <= '0;
    end else if (step) begin
      q_r   <= q_nxt;
      r_r   <= r_nxt;
      cnt_r <= cnt_r + 6'd1;
    end
  end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// EX-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI/LO.
// Handshake: ex_valid marks an instruction in EX; ex_stall (combinational)
// holds it there while high, and the instruction leaves EX on the first edge
// where ex_stall is low. flush cancels EX and any in-flight operation and
// always wins over a commit on the same edge.
module mdu_hilo_ctrl
  import mdu_hilo_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_STEPS  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_mdu_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        ex_stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [1:0]  dbg_state
);

  mdu_state_e  state, state_nxt;
  mdu_op_e     op;
  logic [7:0]  cnt;
  logic [31:0] mul_a, mul_b;
  logic        mul_signed;
  logic        neg_q, neg_r;
  logic        launch_mul, launch_div, wr_hi, wr_lo, commit_mul, commit_div;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [63:0] product;
  logic        div_step, div_last;
  logic [31:0] div_q, div_r;

  assign op        = mdu_op_e'(ex_mdu_op);
  assign dbg_state = state;

  // Signed divide works on magnitudes; the signs are kept for the fix-up.
  assign rs_neg = (op == MDU_DIV) && ex_rs[31];
  assign rt_neg = (op == MDU_DIV) && ex_rt[31];
  assign rs_mag = cond_neg(ex_rs, rs_neg);
  assign rt_mag = cond_neg(ex_rt, rt_neg);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both MULT and MULTU.
  assign product = {{32{mul_signed & mul_a[31]}}, mul_a} *
                   {{32{mul_signed & mul_b[31]}}, mul_b};

  assign div_step = (state == ST_DIV) && !flush;

  // Next-state and control decode; flush overrides everything at the end.
  always_comb begin
    state_nxt  = state;
    ex_stall   = 1'b0;
    launch_mul = 1'b0;
    launch_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    commit_mul = 1'b0;
    commit_div = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              launch_mul = 1'b1;
              ex_stall   = 1'b1;
              state_nxt  = ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              launch_div = 1'b1;
              ex_stall   = 1'b1;
              state_nxt  = ST_DIV;
            end
            MDU_MTHI: wr_hi = 1'b1;
            MDU_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        ex_stall = 1'b1;
        if (cnt == 8'(MUL_CYCLES - 1)) begin
          commit_mul = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DIV: begin
        ex_stall = 1'b1;
        if (div_last) begin
          commit_div = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt  = ST_IDLE;
      ex_stall   = 1'b0;
      launch_mul = 1'b0;
      launch_div = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      commit_mul = 1'b0;
      commit_div = 1'b0;
    end
  end

  // State register; busy is registered from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Operand/sign latches and the multiply cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
    end else begin
      if (launch_mul) begin
        mul_a      <= ex_rs;
        mul_b      <= ex_rt;
        mul_signed <= (op == MDU_MULT);
        cnt        <= '0;
      end else if (state == ST_MUL) begin
        cnt <= cnt + 8'd1;
      end
      if (launch_div) begin
        neg_q <= rs_neg ^ rt_neg;
        neg_r <= rs_neg;
      end
    end
  end

  // Architectural HI/LO: result commits and MTHI/MTLO writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (commit_mul) begin
      hi_out <= product[63:32];
      lo_out <= product[31:0];
    end else if (commit_div) begin
      lo_out <= cond_neg(div_q, neg_q);
      hi_out <= cond_neg(div_r, neg_r);
    end else begin
      if (wr_hi) hi_out <= ex_rs;
      if (wr_lo) lo_out <= ex_rs;
    end
  end

  div_iter #(.STEPS(DIV_STEPS)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (launch_div),
    .step      (div_step),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .last      (div_last),
    .quotient  (div_q),
    .remainder (div_r)
  );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Bench for mdu_hilo_ctrl: vector table of MDU ops, random MULT/MULTU/DIVU,
// and hand sequences for MTHI/MTLO, flush and mid-operation reset.
module tb_mdu_hilo_ctrl;
  import mdu_hilo_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        ex_valid;
  logic [2:0]  ex_mdu_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        flush;
  logic        ex_stall;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    bit          b2b;
    bit          drop;
  } vec_t;

  vec_t vecs[10];

  mdu_hilo_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .ex_valid  (ex_valid),
    .ex_mdu_op (ex_mdu_op),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .flush     (flush),
    .ex_stall  (ex_stall),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] hi, input logic [31:0] lo);
    exp_q.push_back({hi, lo});
  endtask

  task automatic sb_check(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check32({name, "_hi"}, hi_out, e[63:32]);
      check32({name, "_lo"}, lo_out, e[31:0]);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic v, input logic fl);
    @(posedge clk);
    #1;
    ex_mdu_op = op;
    ex_rs     = rs;
    ex_rt     = rt;
    ex_valid  = v;
    flush     = fl;
  endtask

  task automatic idle();
    drive(MDU_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Issue one MUL/DIV op, count stall cycles, then check DONE and HI/LO.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] hi, input logic [31:0] lo, input int stalls,
                        input bit drop, input string name);
    int n;
    n = 0;
    drive(op, rs, rt, 1'b1, 1'b0);
    sb_push(hi, lo);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!ex_stall) break;
      n++;
      if (drop && n == 2) begin
        ex_valid  = 1'b0;
        ex_mdu_op = MDU_NONE;
      end
    end
    check32({name, "_stalls"}, 32'(n), 32'(stalls));
    check32({name, "_done_state"}, 32'(dbg_state), 32'(ST_DONE));
    check32({name, "_done_busy"}, 32'(busy), 32'd1);
    sb_check(name);
  endtask

  initial begin
    logic [31:0] rs, rt, ehi, elo;
    logic [63:0] p;
    logic [2:0]  op;
    longint      sa, sb;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 3,  1'b0, 1'b0};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3,  1'b1, 1'b0};
    vecs[2] = '{MDU_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 33, 1'b0, 1'b0};
    vecs[3] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 1'b0};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1'b0, 1'b0};
    vecs[5] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0, 1'b0};
    vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0, 1'b1};
    vecs[7] = '{MDU_MULT,  32'd2,        32'd3,        32'd0,        32'd6,        3,  1'b0, 1'b1};
    vecs[8] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        3,  1'b0, 1'b0};
    vecs[9] = '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33, 1'b0, 1'b0};

    // Reset.
    resetn    = 1'b0;
    ex_valid  = 1'b0;
    ex_mdu_op = MDU_NONE;
    ex_rs     = '0;
    ex_rt     = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_hi", hi_out, 32'd0);
    check32("reset_lo", lo_out, 32'd0);
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_stall", 32'(ex_stall), 32'd0);
    check32("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    resetn = 1'b1;

    // Vector table; b2b entries launch the next op right after DONE.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo,
             vecs[i].stalls, vecs[i].drop, $sformatf("vec%0d", i));
      if (!vecs[i].b2b) idle();
    end

    // Random MULT/MULTU/DIVU against a behavioural reference.
    for (int i = 0; i < 6; i++) begin
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          op = MDU_MULT;
          sa = longint'($signed(rs));
          sb = longint'($signed(rt));
          p  = 64'(sa * sb);
        end
        1: begin
          op = MDU_MULTU;
          p  = {32'd0, rs} * {32'd0, rt};
        end
        default: begin
          op = MDU_DIVU;
          if (rt == 32'd0) rt = 32'd1;
          p = {rs % rt, rs / rt};
        end
      endcase
      ehi = p[63:32];
      elo = p[31:0];
      run_op(op, rs, rt, ehi, elo, (op == MDU_DIVU) ? 33 : 3, 1'b0, $sformatf("rnd%0d", i));
      idle();
    end

    // MTHI / MTLO without stall, then flushed versions that must not write.
    drive(MDU_MTHI, 32'h1234, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check32("mthi_stall", 32'(ex_stall), 32'd0);
    drive(MDU_MTLO, 32'hABCD, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check32("mthi_hi", hi_out, 32'h1234);
    check32("mtlo_stall", 32'(ex_stall), 32'd0);
    idle();
    @(negedge clk);
    check32("mtlo_lo", lo_out, 32'hABCD);
    drive(MDU_MTHI, 32'h5555, 32'd0, 1'b1, 1'b1);
    sb_push(32'h1234, 32'hABCD);
    @(negedge clk);
    check32("mthi_flush_stall", 32'(ex_stall), 32'd0);
    drive(MDU_MTLO, 32'h6666, 32'd0, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    sb_check("mt_flush");

    // Flush during DIV step 10.
    drive(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    sb_push(32'h1234, 32'hABCD);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check32("flush10_stall", 32'(ex_stall), 32'd0);
    check32("flush10_busy_before", 32'(busy), 32'd1);
    idle();
    @(negedge clk);
    check32("flush10_busy_after", 32'(busy), 32'd0);
    check32("flush10_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (40) @(negedge clk);
    sb_check("flush10");

    // Flush exactly on the commit edge of the last divide step.
    drive(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    sb_push(32'h1234, 32'hABCD);
    repeat (32) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check32("flush_commit_state", 32'(dbg_state), 32'(ST_DIV));
    check32("flush_commit_stall", 32'(ex_stall), 32'd0);
    idle();
    @(negedge clk);
    check32("flush_commit_busy", 32'(busy), 32'd0);
    sb_check("flush_commit");

    // Reset pulsed at DIV step 20, then a fresh MULT.
    drive(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    resetn   = 1'b0;
    ex_valid = 1'b0;
    #1;
    check32("midreset_hi", hi_out, 32'd0);
    check32("midreset_lo", lo_out, 32'd0);
    check32("midreset_busy", 32'(busy), 32'd0);
    check32("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    resetn = 1'b1;
    run_op(MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 3, 1'b0, "post_reset_mult");
    idle();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
